mac_seq_ctrl: RTL and testbench

//  Sequencer that computes wide unsigned products on one 8x8 MULADD slice.
//  - Splits operands into bytes and schedules one partial product per cycle.
//  - Accumulates shifted partial products into a result register.
//  - Returns the result over a valid/ready handshake.
//  - Target for $mul cells too wide for a single MULADD (>8 bits per operand).

---
 rtl/mac_seq_pkg.sv | 24 ++
 rtl/mac_seq_ctrl_core.sv | 21 ++
 rtl/mac_seq_ctrl.sv | 121 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_seq_pkg.sv
// Shared constants, FSM states and step helpers for the byte-serial multiplier.
package mac_seq_pkg;

    localparam int MUL_W      = 8;
    localparam int PROD_W     = 16;
    localparam int MULADD_C_W = 20;

    localparam logic [5:0] MULADD_CFG_UMUL = 6'b000000;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DONE
    } state_e;

    // Bit offset of partial product (i,j): 8*(i+j).
    function automatic logic [31:0] step_shift(
        input logic [31:0] step,
        input logic [31:0] b_bytes
    );
        return 32'(MUL_W) * ((step / b_bytes) + (step % b_bytes));
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_core.sv
// 8x8 -> 16 unsigned MULADD slice, behavioural model of the hard cell.
module muladd_core8
    import mac_seq_pkg::*;
(
    input  logic [MUL_W-1:0]      a_i,
    input  logic [MUL_W-1:0]      b_i,
    input  logic [MULADD_C_W-1:0] c_i,
    input  logic [5:0]            cfg_i,
    output logic [PROD_W-1:0]     p_o
);

    logic [PROD_W-1:0] prod_w;

    assign prod_w = PROD_W'(a_i) * PROD_W'(b_i);

    // Only the unsigned configuration is modelled.
    assign p_o = (cfg_i == MULADD_CFG_UMUL)
               ? PROD_W'({{(MULADD_C_W-PROD_W){1'b0}}, prod_w} + c_i)
               : '0;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Byte-serial wide multiplier on one 8x8 MULADD slice.
// Define MAC_SEQ_ACC_EN to add the in_acc accumulate-on-accept port.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int A_BYTES = 2,
    parameter int B_BYTES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [8*A_BYTES-1:0]            in_a,
    input  logic [8*B_BYTES-1:0]            in_b,
`ifdef MAC_SEQ_ACC_EN
    input  logic                            in_acc,
`endif
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [8*(A_BYTES+B_BYTES)-1:0]  out_data,
    output logic                            busy
);

    localparam int AW    = 8 * A_BYTES;
    localparam int BW    = 8 * B_BYTES;
    localparam int RW    = AW + BW;
    localparam int NSTEP = A_BYTES * B_BYTES;
    localparam int SW    = $clog2(NSTEP) + 1;

    state_e         state_q;
    logic [AW-1:0]  a_q;
    logic [BW-1:0]  b_q;
    logic [RW-1:0]  acc_q;
    logic [RW-1:0]  acc_d;
    logic [SW-1:0]  step_q;
    logic           out_valid_q;
    logic           busy_q;

    logic [31:0]        step_w;
    logic [31:0]        i_w;
    logic [31:0]        j_w;
    logic [31:0]        sh_w;
    logic [MUL_W-1:0]   a_byte;
    logic [MUL_W-1:0]   b_byte;
    logic [PROD_W-1:0]  core_p;
    logic [RW-1:0]      pp_w;

    assign step_w = 32'(step_q);
    assign i_w    = step_w / 32'(B_BYTES);
    assign j_w    = step_w % 32'(B_BYTES);
    assign sh_w   = step_shift(step_w, 32'(B_BYTES));

    assign a_byte = MUL_W'(a_q >> (i_w * 32'(MUL_W)));
    assign b_byte = MUL_W'(b_q >> (j_w * 32'(MUL_W)));

    muladd_core8 u_core (
        .a_i   (a_byte),
        .b_i   (b_byte),
        .c_i   ('0),
        .cfg_i (MULADD_CFG_UMUL),
        .p_o   (core_p)
    );

    assign pp_w  = RW'(core_p) << sh_w;
    assign acc_d = acc_q + pp_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
`ifdef MAC_SEQ_ACC_EN
                        acc_q   <= in_acc ? acc_q : '0;
`else
                        acc_q   <= '0;
`endif
                        step_q  <= '0;
                        busy_q  <= 1'b1;
                        state_q <= STEP;
                    end
                end
                STEP: begin
                    acc_q  <= acc_d;
                    step_q <= step_q + 1'b1;
                    if (step_q == SW'(NSTEP - 1)) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl with a result scoreboard.
// Build with MAC_SEQ_ACC_EN to also exercise accumulate mode.
module tb_mac_seq_ctrl;

    localparam int AW = 16;
    localparam int BW = 16;
    localparam int RW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] in_a = '0;
    logic [BW-1:0] in_b = '0;
    logic          in_acc = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [RW-1:0] out_data;
    logic          busy;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int prev_acc_cyc = 0;
    logic [RW-1:0] sb[$];
    logic [RW-1:0] model = '0;

    mac_seq_ctrl #(.A_BYTES(2), .B_BYTES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
`ifdef MAC_SEQ_ACC_EN
        .in_acc    (in_acc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: compare on every result handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                check("result", 64'(out_data), 64'(sb.pop_front()));
            end
            check("no_ready_in_done", 64'(in_ready), 64'd0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("in_ready_wait", 64'(in_ready), 64'd1);
    endtask

    task automatic do_op(input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input logic acc, input bit push);
        logic [RW-1:0] prod;
        wait_ready();
        in_a     = a;
        in_b     = b;
        in_acc   = acc;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        prev_acc_cyc = acc_cyc;
        acc_cyc  = cyc;
        if (push) begin
            prod = RW'(a) * RW'(b);
`ifdef MAC_SEQ_ACC_EN
            model = acc ? model + prod : prod;
`else
            model = prod;
`endif
            sb.push_back(model);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || !in_ready) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // Single op, result held in DONE by back-pressure.
        out_ready = 1'b0;
        do_op(16'h1234, 16'h5678, 1'b0, 1'b1);
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_in_ready", 64'(in_ready), 64'd0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency", 64'(cyc - acc_cyc), 64'd4);

        in_a     = 16'h0002;
        in_b     = 16'h0003;
        in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'h06260060);
            check("hold_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("post_hs_valid", 64'(out_valid), 64'd0);
        check("post_hs_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        check("ignored_op_busy", 64'(busy), 64'd0);

        // Extremes.
        out_ready = 1'b1;
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        do_op(16'h0000, 16'hABCD, 1'b0, 1'b1);
        drain();

        // Reset while step 2 is in progress.
        out_ready = 1'b0;
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("step2_busy", 64'(busy), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_data", 64'(out_data), 64'd0);
        model = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("abort_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        do_op(16'h00FF, 16'h0100, 1'b0, 1'b1);
        drain();

        // Back-to-back with out_ready tied high.
        do_op(16'h0102, 16'h0304, 1'b0, 1'b1);
        do_op(16'hBEEF, 16'h1001, 1'b0, 1'b1);
        check("ii_1", 64'(acc_cyc - prev_acc_cyc), 64'd6);
        do_op(16'h8000, 16'h0002, 1'b0, 1'b1);
        check("ii_2", 64'(acc_cyc - prev_acc_cyc), 64'd6);
        do_op(16'h00A5, 16'h5A00, 1'b0, 1'b1);
        check("ii_3", 64'(acc_cyc - prev_acc_cyc), 64'd6);
        drain();

`ifdef MAC_SEQ_ACC_EN
        do_op(16'd3, 16'd5, 1'b0, 1'b1);
        drain();
        check("acc_first", 64'(out_data), 64'd15);
        do_op(16'd7, 16'd9, 1'b1, 1'b1);
        drain();
        check("acc_sum", 64'(out_data), 64'd78);
        do_op(16'd7, 16'd9, 1'b0, 1'b1);
        drain();
        check("acc_clear", 64'(out_data), 64'd63);
`endif

        repeat (2) @(posedge clk);
        #1;
        check("sb_final", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
